// File: rtl/t_ff_count_ctrl.sv
// Up/down counter built on a bank of four T flip-flops, sequenced by a small FSM.
// The FSM decides, every cycle, which bits of the bank toggle.
//
// Ports:
//   clk    - single clock; all state changes on its rising edge
//   clear  - synchronous active-high reset
//   start  - start from IDLE (latches up_dn/limit) or resume from PAUSE
//   stop   - pause request while running
//   up_dn  - direction, 1 = up, 0 = down; sampled on an accepted start from IDLE
//   limit  - terminal value; sampled on an accepted start from IDLE
//   count  - registered count held by the T-FF bank
//   t_en   - combinational toggle enables applied to the bank this cycle
//   busy   - high while running or paused
//   done   - registered one-cycle completion pulse
//
// Build option: define AUTO_RELOAD_EN to make the counter reload its start value on
// reaching the terminal value and keep running instead of passing through DONE.

module t_ff_count_ctrl (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic       up_dn,
  input  logic [3:0] limit,
  output logic [3:0] count,
  output logic [3:0] t_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] count_q;
  logic [3:0] lim_q, lim_d;
  logic       dir_q, dir_d;
  logic       done_q, done_d;

  logic       load;
  logic [3:0] load_val;
  logic [3:0] term;
  logic       at_term;
  logic [3:0] step_en;

  assign term    = dir_q ? lim_q : 4'd0;
  assign at_term = (count_q == term);

  // Ripple-carry style enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    step_en[0] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step_en[i] = step_en[i-1] & (dir_q ? count_q[i-1] : ~count_q[i-1]);
    end
  end

  // State register and T-FF bank.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      lim_q   <= 4'd0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= load ? load_val : (count_q ^ t_en);
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = 4'd0;
    dir_d    = dir_q;
    lim_d    = lim_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          load     = 1'b1;
          dir_d    = up_dn;
          lim_d    = limit;
          load_val = up_dn ? 4'd0 : limit;
        end
      end
      StRun: begin
        // Terminal check wins over stop.
        if (at_term) begin
`ifdef AUTO_RELOAD_EN
          load     = 1'b1;
          load_val = dir_q ? 4'd0 : lim_q;
          done_d   = 1'b1;
`else
          state_d  = StDone;
          done_d   = 1'b1;
`endif
        end else if (stop) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    t_en = 4'd0;
    if (!clear && (state_q == StRun) && !at_term && !stop) begin
      t_en = step_en;
    end
    busy  = !clear && ((state_q == StRun) || (state_q == StPause));
    done  = done_q;
    count = count_q;
  end

endmodule

// File: tb/tb_t_ff_count_ctrl.sv
module tb_t_ff_count_ctrl;

  logic       clk;
  logic       clear;
  logic       start;
  logic       stop;
  logic       up_dn;
  logic [3:0] limit;
  logic [3:0] count;
  logic [3:0] t_en;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  t_ff_count_ctrl dut (
    .clk   (clk),
    .clear (clear),
    .start (start),
    .stop  (stop),
    .up_dn (up_dn),
    .limit (limit),
    .count (count),
    .t_en  (t_en),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase names, plain integer count.
  localparam int PIdle  = 0;
  localparam int PRun   = 1;
  localparam int PPause = 2;
  localparam int PDone  = 3;

  int m_phase;
  int m_cnt;
  int m_lim;
  int m_up;
  int m_done;
  bit m_valid = 1'b0;

  function automatic int m_term();
    return m_up ? m_lim : 0;
  endfunction

  always @(posedge clk) begin
    if (clear) begin
      m_phase = PIdle;
      m_cnt   = 0;
      m_lim   = 0;
      m_up    = 1;
      m_done  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 0;
      case (m_phase)
        PIdle: if (start) begin
          m_up    = int'(up_dn);
          m_lim   = int'(limit);
          m_cnt   = up_dn ? 0 : int'(limit);
          m_phase = PRun;
        end
        PRun: begin
          if (m_cnt == m_term()) begin
            m_done = 1;
`ifdef AUTO_RELOAD_EN
            m_cnt = m_up ? 0 : m_lim;
`else
            m_phase = PDone;
`endif
          end else if (stop) begin
            m_phase = PPause;
          end else begin
            m_cnt = m_up ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
          end
        end
        PPause: if (start) m_phase = PRun;
        default: m_phase = PIdle;
      endcase
    end
  end

  // Compare process: outputs checked against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    int e_ten;
    int e_busy;
    if (m_valid) begin
      e_ten  = 0;
      e_busy = (!clear && (m_phase == PRun || m_phase == PPause)) ? 1 : 0;
      if (!clear && m_phase == PRun && m_cnt != m_term() && !stop) begin
        e_ten = m_up ? (m_cnt ^ ((m_cnt + 1) % 16)) : (m_cnt ^ ((m_cnt + 15) % 16));
      end
      check("model_count", int'(count), m_cnt);
      check("model_t_en", int'(t_en), e_ten);
      check("model_busy", int'(busy), e_busy);
      check("model_done", int'(done), m_done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    up_dn = 1'b1;
    limit = 4'd0;
    step();
    step();
    check("reset_count", int'(count), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_t_en", int'(t_en), 0);
    clear = 1'b0;

    // Up to 5.
    start = 1'b1; up_dn = 1'b1; limit = 4'd5;
    step();
    start = 1'b0;
    check("up5_first", int'(count), 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("up5_count", int'(count), i);
    end
    step();
    check("up5_done", int'(done), 1);
    check("up5_busy", int'(busy), 0);
    step();
    check("up5_done_gone", int'(done), 0);
    check("up5_hold", int'(count), 5);

    // Down from 9, with the carry-pattern enables.
    start = 1'b1; up_dn = 1'b0; limit = 4'd9;
    step();
    start = 1'b0; up_dn = 1'b1; limit = 4'd2;
    check("dn9_first", int'(count), 9);
    for (int i = 9; i >= 1; i--) begin
      @(negedge clk);
      if (i == 8) check("dn9_t_en_8", int'(t_en), 15);
      if (i == 7) check("dn9_t_en_7", int'(t_en), 1);
      step();
      check("dn9_count", int'(count), i - 1);
    end
    step();
    check("dn9_done", int'(done), 1);
    step();

    // Pause at 4 for three cycles, then resume.
    start = 1'b1; up_dn = 1'b1; limit = 4'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_hold", int'(count), 4);
      check("pause_busy", int'(busy), 1);
    end
    stop = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("resume_end", int'(count), 10);
    step();
    check("resume_done", int'(done), 1);
    step();

    // Clear mid-run at 7.
    start = 1'b1; up_dn = 1'b1; limit = 4'd12;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("midclr_pre", int'(count), 7);
    clear = 1'b1;
    @(negedge clk);
    check("midclr_busy_comb", int'(busy), 0);
    check("midclr_t_en_comb", int'(t_en), 0);
    step();
    clear = 1'b0;
    check("midclr_count", int'(count), 0);
    check("midclr_busy", int'(busy), 0);
    step();
    check("midclr_no_done", int'(done), 0);

    // limit 0, then full 0..15 with a mid-run limit change.
    start = 1'b1; up_dn = 1'b1; limit = 4'd0;
    step();
    start = 1'b0;
    step();
    check("lim0_done", int'(done), 1);
    step();
    start = 1'b1; limit = 4'd15;
    step();
    start = 1'b0; limit = 4'd3;
    for (int i = 0; i < 15; i++) step();
    check("full_end", int'(count), 15);
    step();
    check("full_done", int'(done), 1);
    step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      clear = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 5) == 0);
      up_dn = 1'($urandom_range(0, 1));
      limit = 4'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
